// File: rtl/soc_or1k_jtag_pkg.sv
// Shared types and constants for the OR1K JTAG TAP controller.
package soc_or1k_jtag_pkg;

    // 16-state IEEE 1149.1 TAP controller state encoding.
    typedef enum logic [3:0] {
        ST_TLR     = 4'h0,
        ST_RTI     = 4'h1,
        ST_SELDR   = 4'h2,
        ST_CAPDR   = 4'h3,
        ST_SHIFTDR = 4'h4,
        ST_EXIT1DR = 4'h5,
        ST_PAUSEDR = 4'h6,
        ST_EXIT2DR = 4'h7,
        ST_UPDDR   = 4'h8,
        ST_SELIR   = 4'h9,
        ST_CAPIR   = 4'hA,
        ST_SHIFTIR = 4'hB,
        ST_EXIT1IR = 4'hC,
        ST_PAUSEIR = 4'hD,
        ST_EXIT2IR = 4'hE,
        ST_UPDIR   = 4'hF
    } tap_state_e;

    localparam int IR_LENGTH_DEF = 4;

    // Instruction opcodes; anything not decoded below behaves as BYPASS.
    localparam logic [3:0] INSN_EXTEST         = 4'b0000;
    localparam logic [3:0] INSN_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] INSN_IDCODE         = 4'b0010;
    localparam logic [3:0] INSN_DEBUG          = 4'b1000;
    localparam logic [3:0] INSN_MBIST          = 4'b1001;
    localparam logic [3:0] INSN_BYPASS         = 4'b1111;

    // Pattern loaded into the IR shift register in CAPTURE_IR (bit0=1, bit1=0).
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

endpackage

// File: rtl/soc_or1k_jtag_tap_fsm.sv
// TAP state machine: state register, next-state decode from TMS and
// combinational state-decode strobes for the debug interface.
module soc_or1k_jtag_tap_fsm
    import soc_or1k_jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       rst_n_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output tap_state_e state_next_o,
    output logic       test_logic_reset_o,
    output logic       run_test_idle_o,
    output logic       shift_dr_o,
    output logic       pause_dr_o,
    output logic       update_dr_o,
    output logic       capture_dr_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register, forced to TEST_LOGIC_RESET by trst.
    always_ff @(posedge tck_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode following the standard TAP state diagram.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TLR:     state_d = tms_i ? ST_TLR     : ST_RTI;
            ST_RTI:     state_d = tms_i ? ST_SELDR   : ST_RTI;
            ST_SELDR:   state_d = tms_i ? ST_SELIR   : ST_CAPDR;
            ST_CAPDR:   state_d = tms_i ? ST_EXIT1DR : ST_SHIFTDR;
            ST_SHIFTDR: state_d = tms_i ? ST_EXIT1DR : ST_SHIFTDR;
            ST_EXIT1DR: state_d = tms_i ? ST_UPDDR   : ST_PAUSEDR;
            ST_PAUSEDR: state_d = tms_i ? ST_EXIT2DR : ST_PAUSEDR;
            ST_EXIT2DR: state_d = tms_i ? ST_UPDDR   : ST_SHIFTDR;
            ST_UPDDR:   state_d = tms_i ? ST_SELDR   : ST_RTI;
            ST_SELIR:   state_d = tms_i ? ST_TLR     : ST_CAPIR;
            ST_CAPIR:   state_d = tms_i ? ST_EXIT1IR : ST_SHIFTIR;
            ST_SHIFTIR: state_d = tms_i ? ST_EXIT1IR : ST_SHIFTIR;
            ST_EXIT1IR: state_d = tms_i ? ST_UPDIR   : ST_PAUSEIR;
            ST_PAUSEIR: state_d = tms_i ? ST_EXIT2IR : ST_PAUSEIR;
            ST_EXIT2IR: state_d = tms_i ? ST_UPDIR   : ST_SHIFTIR;
            ST_UPDIR:   state_d = tms_i ? ST_SELDR   : ST_RTI;
            default:    state_d = ST_TLR;
        endcase
    end

    assign state_o            = state_q;
    assign state_next_o       = state_d;
    assign test_logic_reset_o = (state_q == ST_TLR);
    assign run_test_idle_o    = (state_q == ST_RTI);
    assign shift_dr_o         = (state_q == ST_SHIFTDR);
    assign pause_dr_o         = (state_q == ST_PAUSEDR);
    assign update_dr_o        = (state_q == ST_UPDDR);
    assign capture_dr_o       = (state_q == ST_CAPDR);

endmodule

// File: rtl/soc_or1k_jtag_tap.sv
// OR1K JTAG TAP controller: instruction register, IDCODE and BYPASS data
// registers and the falling-edge tdo mux. The debug unit owns its own DR.
module soc_or1k_jtag_tap
    import soc_or1k_jtag_pkg::*;
#(
    parameter int          IR_LENGTH    = IR_LENGTH_DEF,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
    input  logic tck_pad_i,
    input  logic trstn_pad_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o,
    output logic tdo_padoe_o,
    output logic test_logic_reset_o,
    output logic run_test_idle_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic debug_select_o,
    output logic tdi_o,
    input  logic debug_tdo_i
);

    localparam logic [IR_LENGTH-1:0] IR_CAP    = IR_LENGTH'(IR_CAPTURE);
    localparam logic [IR_LENGTH-1:0] IR_IDCODE = IR_LENGTH'(INSN_IDCODE);
    localparam logic [IR_LENGTH-1:0] IR_DEBUG  = IR_LENGTH'(INSN_DEBUG);

    tap_state_e state_s;
    tap_state_e state_next_s;
    logic       srst_s;

    logic [IR_LENGTH-1:0] ir_sh_q, ir_sh_d;
    logic [IR_LENGTH-1:0] ir_q, ir_d;
    logic                 debug_select_q, debug_select_d;
    logic [31:0]          idcode_q, idcode_d;
    logic                 bypass_q, bypass_d;
    logic                 tdo_q, tdo_d;
    logic                 tdo_oe_q, tdo_oe_d;

    soc_or1k_jtag_tap_fsm u_fsm (
        .tck_i              (tck_pad_i),
        .rst_n_i            (trstn_pad_i),
        .tms_i              (tms_pad_i),
        .state_o            (state_s),
        .state_next_o       (state_next_s),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o),
        .capture_dr_o       (capture_dr_o)
    );

    // Entering (or staying in) TEST_LOGIC_RESET clears the registers on the
    // same edge, so IR already reads IDCODE once the FSM sits in TLR.
    assign srst_s = (state_next_s == ST_TLR);

    // Rising-edge register updates: IR capture/shift/update and DR capture/shift.
    always_comb begin
        ir_sh_d        = ir_sh_q;
        ir_d           = ir_q;
        debug_select_d = debug_select_q;
        idcode_d       = idcode_q;
        bypass_d       = bypass_q;
        if (srst_s) begin
            ir_sh_d        = '0;
            ir_d           = IR_IDCODE;
            debug_select_d = 1'b0;
            idcode_d       = 32'h0000_0000;
            bypass_d       = 1'b0;
        end else begin
            case (state_s)
                ST_CAPIR: begin
                    ir_sh_d = IR_CAP;
                end
                ST_SHIFTIR: begin
                    ir_sh_d = {tdi_pad_i, ir_sh_q[IR_LENGTH-1:1]};
                end
                ST_UPDIR: begin
                    ir_d           = ir_sh_q;
                    debug_select_d = (ir_sh_q == IR_DEBUG);
                end
                ST_CAPDR: begin
                    bypass_d = 1'b0;
                    if (ir_q == IR_IDCODE) begin
                        idcode_d = IDCODE_VALUE;
                    end else begin
                        idcode_d = idcode_q;
                    end
                end
                ST_SHIFTDR: begin
                    bypass_d = tdi_pad_i;
                    if (ir_q == IR_IDCODE) begin
                        idcode_d = {tdi_pad_i, idcode_q[31:1]};
                    end else begin
                        idcode_d = idcode_q;
                    end
                end
                default: begin
                    ir_sh_d = ir_sh_q;
                end
            endcase
        end
    end

    // Rising-edge state for IR and data registers, cleared asynchronously by trst.
    always_ff @(posedge tck_pad_i or negedge trstn_pad_i) begin
        if (!trstn_pad_i) begin
            ir_sh_q        <= '0;
            ir_q           <= IR_IDCODE;
            debug_select_q <= 1'b0;
            idcode_q       <= 32'h0000_0000;
            bypass_q       <= 1'b0;
        end else begin
            ir_sh_q        <= ir_sh_d;
            ir_q           <= ir_d;
            debug_select_q <= debug_select_d;
            idcode_q       <= idcode_d;
            bypass_q       <= bypass_d;
        end
    end

    // tdo source select; outside the shift states tdo holds its last value.
    always_comb begin
        tdo_d    = tdo_q;
        tdo_oe_d = (state_s == ST_SHIFTIR) || (state_s == ST_SHIFTDR);
        case (state_s)
            ST_TLR: begin
                tdo_d = 1'b0;
            end
            ST_SHIFTIR: begin
                tdo_d = ir_sh_q[0];
            end
            ST_SHIFTDR: begin
                if (ir_q == IR_IDCODE) begin
                    tdo_d = idcode_q[0];
                end else if (ir_q == IR_DEBUG) begin
                    tdo_d = debug_tdo_i;
                end else begin
                    tdo_d = bypass_q;
                end
            end
            default: begin
                tdo_d = tdo_q;
            end
        endcase
    end

    // Falling-edge tdo and output-enable registers.
    always_ff @(negedge tck_pad_i or negedge trstn_pad_i) begin
        if (!trstn_pad_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo_pad_o      = tdo_q;
    assign tdo_padoe_o    = tdo_oe_q;
    assign debug_select_o = debug_select_q;
    assign tdi_o          = tdi_pad_i;

endmodule

// File: tb/tb_soc_or1k_jtag_tap.sv
// Directed testbench for the OR1K JTAG TAP controller.
module tb_soc_or1k_jtag_tap;

    logic tck, trstn, tms, tdi, debug_tdo;
    logic tdo, tdo_oe, tlr, rti, sdr, pdr, udr, cdr, dbg_sel, tdi_pass;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] IDCODE = 32'h149511C3;

    soc_or1k_jtag_tap dut (
        .tck_pad_i          (tck),
        .trstn_pad_i        (trstn),
        .tms_pad_i          (tms),
        .tdi_pad_i          (tdi),
        .tdo_pad_o          (tdo),
        .tdo_padoe_o        (tdo_oe),
        .test_logic_reset_o (tlr),
        .run_test_idle_o    (rti),
        .shift_dr_o         (sdr),
        .pause_dr_o         (pdr),
        .update_dr_o        (udr),
        .capture_dr_o       (cdr),
        .debug_select_o     (dbg_sel),
        .tdi_o              (tdi_pass),
        .debug_tdo_i        (debug_tdo)
    );

    // One tck period: inputs set while low, rise at +4, fall at +9, sample at +10.
    task automatic tick(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        #4 tck = 1'b1;
        #5 tck = 1'b0;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // From RTI: load an IR value, returning the four tdo bits seen while shifting.
    task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cap[0] = tdo;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, val[i]);
            if (i < 3) cap[i+1] = tdo;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI: DR scan of n shifts; dout[k] is tdo presented before shift k.
    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = 32'h0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        dout[0] = tdo;
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i]);
            if (i < n - 1) dout[i+1] = tdo;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #2 trstn = 1'b0;
        #3;
        chk("rst_tlr", {31'd0, tlr}, 32'd1);
        chk("rst_rti", {31'd0, rti}, 32'd0);
        chk("rst_sdr", {31'd0, sdr}, 32'd0);
        chk("rst_tdo", {31'd0, tdo}, 32'd0);
        chk("rst_oe", {31'd0, tdo_oe}, 32'd0);
        chk("rst_dbg", {31'd0, dbg_sel}, 32'd0);
        trstn = 1'b1;
        #2;
    endtask

    task automatic test_idcode();
        logic [31:0] got;
        int oe_bad;
        got = 32'h0;
        oe_bad = 0;
        tick(1'b0, 1'b0);
        chk("id_rti", {31'd0, rti}, 32'd1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("id_cdr", {31'd0, cdr}, 32'd1);
        chk("id_oe_cap", {31'd0, tdo_oe}, 32'd0);
        tick(1'b0, 1'b0);
        chk("id_sdr", {31'd0, sdr}, 32'd1);
        got[0] = tdo;
        if (tdo_oe !== 1'b1) oe_bad++;
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, 1'b0);
            got[i] = tdo;
            if (tdo_oe !== 1'b1) oe_bad++;
        end
        chk("id_value", got, IDCODE);
        chk("id_oe_shift", oe_bad, 32'd0);
        tick(1'b1, 1'b0);
        chk("id_oe_exit", {31'd0, tdo_oe}, 32'd0);
        tick(1'b1, 1'b0);
        chk("id_upd", {31'd0, udr}, 32'd1);
        tick(1'b0, 1'b1);
        chk("id_upd_end", {31'd0, udr}, 32'd0);
        chk("tdi_pass1", {31'd0, tdi_pass}, 32'd1);
        tdi = 1'b0;
        #1;
        chk("tdi_pass0", {31'd0, tdi_pass}, 32'd0);
    endtask

    task automatic test_ir_bypass();
        logic [3:0]  cap;
        logic [31:0] d;
        load_ir(4'b1111, cap);
        chk("ir_capture", {28'd0, cap}, 32'h5);
        chk("byp_dbg", {31'd0, dbg_sel}, 32'd0);
        scan_dr(5, 32'b01101, d);
        chk("byp_data", {27'd0, d[4:0]}, 32'b11010);
    endtask

    task automatic test_tlr_return();
        logic [31:0] d;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("tlr_in_shiftir", {31'd0, tdo_oe}, 32'd1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        chk("tlr_reached", {31'd0, tlr}, 32'd1);
        chk("tlr_oe", {31'd0, tdo_oe}, 32'd0);
        tick(1'b0, 1'b0);
        scan_dr(8, 32'h0, d);
        chk("tlr_ir_idcode", {24'd0, d[7:0]}, 32'hC3);
    endtask

    task automatic test_debug();
        logic [3:0] cap;
        load_ir(4'b1000, cap);
        chk("dbg_sel_set", {31'd0, dbg_sel}, 32'd1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        debug_tdo = 1'b1;
        tick(1'b0, 1'b0);
        chk("dbg_tdo_1", {31'd0, tdo}, 32'd1);
        debug_tdo = 1'b0;
        tick(1'b0, 1'b0);
        chk("dbg_tdo_0", {31'd0, tdo}, 32'd0);
        debug_tdo = 1'b1;
        tick(1'b0, 1'b0);
        chk("dbg_tdo_1b", {31'd0, tdo}, 32'd1);
        debug_tdo = 1'b0;
        tick(1'b1, 1'b0);
        chk("dbg_tdo_hold", {31'd0, tdo}, 32'd1);
        tick(1'b1, 1'b0);
        chk("dbg_upd", {31'd0, udr}, 32'd1);
        chk("dbg_sel_hold", {31'd0, dbg_sel}, 32'd1);
        tick(1'b0, 1'b0);
        chk("dbg_upd_pulse", {31'd0, udr}, 32'd0);
        chk("dbg_sel_rti", {31'd0, dbg_sel}, 32'd1);
    endtask

    task automatic test_unknown();
        logic [3:0]  cap;
        logic [31:0] d;
        load_ir(4'b0111, cap);
        chk("unk_dbg", {31'd0, dbg_sel}, 32'd0);
        scan_dr(3, 32'b110, d);
        chk("unk_bypass", {29'd0, d[2:0]}, 32'b100);
    endtask

    task automatic test_async_reset();
        logic [31:0] got, d, idv;
        idv = IDCODE;
        got = 32'h0;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        got[0] = tdo;
        for (int i = 1; i < 18; i++) begin
            tick(1'b0, 1'b0);
            got[i] = tdo;
        end
        chk("ar_partial", {14'd0, got[17:0]}, {14'd0, idv[17:0]});
        chk("ar_pre_oe", {31'd0, tdo_oe}, 32'd1);
        trstn = 1'b0;
        #3;
        chk("ar_tlr", {31'd0, tlr}, 32'd1);
        chk("ar_sdr", {31'd0, sdr}, 32'd0);
        chk("ar_tdo", {31'd0, tdo}, 32'd0);
        chk("ar_oe", {31'd0, tdo_oe}, 32'd0);
        trstn = 1'b1;
        #2;
        tick(1'b0, 1'b0);
        scan_dr(32, 32'h0, d);
        chk("ar_rescan", d, IDCODE);
    endtask

    initial begin
        tck = 1'b0;
        trstn = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        debug_tdo = 1'b0;
        test_reset();
        test_idcode();
        test_ir_bypass();
        test_tlr_return();
        test_debug();
        test_unknown();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_or1k_jtag_tap.md
Name: soc_or1k_jtag_tap

Overview:
IEEE 1149.1 TAP controller: the responding end of the JTAG link driven by the simulation JTAG VPI (tms/tck/tdi in, tdo out).
- Decodes the TMS sequence into the 16-state TAP FSM.
- Holds the instruction register, IDCODE and BYPASS data registers.
- Exports select/strobe signals to the debug interface, which owns its own DR chain.
- One instance per tdo pad of the SoC.

Parameters:
IR_LENGTH, 4, instruction register width in bits.
IDCODE_VALUE, 32'h149511C3, value captured into the IDCODE DR. Bit 0 must be 1.

Ports:
tck_pad_i  input  1  TAP clock, the only clock. Rising edge samples tms/tdi; falling edge updates tdo.
trstn_pad_i  input  1  asynchronous, active-low reset.
tms_pad_i  input  1  test mode select.
tdi_pad_i  input  1  test data in.
tdo_pad_o  output  1  test data out.
tdo_padoe_o  output  1  tdo output enable.
test_logic_reset_o  output  1  FSM is in TEST_LOGIC_RESET.
run_test_idle_o  output  1  FSM is in RUN_TEST_IDLE.
shift_dr_o  output  1  FSM is in SHIFT_DR.
pause_dr_o  output  1  FSM is in PAUSE_DR.
update_dr_o  output  1  FSM is in UPDATE_DR.
capture_dr_o  output  1  FSM is in CAPTURE_DR.
debug_select_o  output  1  latched IR equals DEBUG.
tdi_o  output  1  tdi_pad_i passed through to the debug chain.
debug_tdo_i  input  1  serial output of the debug chain.

Behaviour:
- Interface: single clock tck_pad_i; reset trstn_pad_i is asynchronous and active-low.
- FSM states and transitions (next state on tck rise):
  - TLR: tms=0 -> RTI, else stay.
  - RTI: tms=1 -> SELDR, else stay.
  - SELDR: tms=1 -> SELIR, else CAPDR.
  - SELIR: tms=1 -> TLR, else CAPIR.
  - CAPxR: tms=1 -> EXIT1xR, else SHIFTxR.
  - SHIFTxR: tms=1 -> EXIT1xR, else stay.
  - EXIT1xR: tms=1 -> UPDxR, else PAUSExR.
  - PAUSExR: tms=1 -> EXIT2xR, else stay.
  - EXIT2xR: tms=1 -> UPDxR, else SHIFTxR.
  - UPDxR: tms=1 -> SELDR, else RTI.
- Any state with five consecutive tms=1 cycles must reach TLR.
- Reset (trstn low, or FSM in TLR):
  - state=TLR, latched IR=IDCODE (4'b0010), IR shift reg=0, bypass=0.
  - tdo_pad_o=0, tdo_padoe_o=0, debug_select_o=0.
- Instruction codes:
  - EXTEST 0000, SAMPLE_PRELOAD 0001, IDCODE 0010, DEBUG 1000, MBIST 1001, BYPASS 1111.
  - Any other code behaves as BYPASS.
- IR path:
  - CAPIR loads shift reg with 4'b0101 (LSB=1, bit1=0 per standard).
  - SHIFTIR shifts right, tdi_pad_i entering the MSB.
  - UPDIR copies shift reg into latched IR.
- IDCODE DR:
  - CAPDR with IR=IDCODE loads IDCODE_VALUE.
  - SHIFTDR shifts right, tdi into bit 31.
- BYPASS DR: CAPDR loads 0; SHIFTDR loads tdi_pad_i.
- tdo mux, evaluated on tck fall:
  - SHIFTIR: IR shift reg bit0.
  - SHIFTDR with IDCODE: idcode bit0.
  - SHIFTDR with DEBUG: debug_tdo_i.
  - SHIFTDR with any other IR: bypass bit.
  - Otherwise: hold the previous value.
- tdo_padoe_o: registered on tck fall; 1 exactly while the state is SHIFTIR or SHIFTDR.
- State-decode outputs (test_logic_reset_o … capture_dr_o) are combinational from the current state, so update_dr_o lasts exactly one tck period per UPDDR visit.
- debug_select_o changes only at UPDIR; it holds through DR scans.
- Reset asserted mid-shift: all registers go to reset values immediately, independent of tck. Nothing partial is latched into IR.
- tdi_o = tdi_pad_i, combinational.

Decomposition:
- Package soc_or1k_jtag_pkg:
  - 4-bit TAP state enum (16 states).
  - IR_LENGTH default.
  - Instruction code localparams.
  - IR capture pattern.
- Sub-module soc_or1k_jtag_tap_fsm: state register plus next-state logic and state-decode outputs.
- Top level holds the IR, IDCODE and BYPASS registers and the tdo mux.

Test Plan:
- Reset, then one IDCODE scan: pulse trstn low; TMS 0,1,0,0 reaches SHIFTDR; shift 32 bits with tdi=0 -> tdo sequence LSB-first forms 32'h149511C3; tdo_padoe_o=1 only during SHIFTDR.
- Return to TLR: from SHIFTIR, drive tms=1 for 5 tck -> test_logic_reset_o=1, latched IR=4'b0010.
- IR capture and BYPASS: shift IR=4'b1111 -> first 4 tdo bits are 1,0,1,0. Then a DR scan with tdi pattern 1,0,1,1 -> tdo returns the same pattern delayed by one tck.
- DEBUG select: load IR=4'b1000 -> debug_select_o=1 after UPDIR. In SHIFTDR, tdo tracks debug_tdo_i. One UPDDR gives a single-cycle update_dr_o pulse.
- Unknown opcode: IR=4'b0111 -> DR path behaves as 1-bit bypass; debug_select_o=0.
- Async reset mid-scan: assert trstn low at bit 17 of an IDCODE scan with tck stopped -> outputs reach reset values without a tck edge; the next scan reads IDCODE again.
